// File: rtl/history_manager_if.sv
// history_manager_if: prediction, resolution and history bundle for the branch history manager
interface history_manager_if #(
    parameter int GLOBAL_HISTORY_WIDTH     = 128,
    parameter int PATH_HISTORY_NUM_ENTRIES = 4,
    parameter int PATH_HISTORY_HASH_WIDTH  = 16,
    parameter int PC_WIDTH                 = 64,
    parameter int CKPT_DEPTH               = 8
);
    localparam int TW = $clog2(CKPT_DEPTH);
    logic                                                               pred_valid;
    logic                                                               pred_ready;
    logic [PC_WIDTH-1:0]                                                pred_pc;
    logic                                                               pred_taken;
    logic [TW-1:0]                                                      pred_tag;
    logic                                                               resolve_valid;
    logic                                                               resolve_mispredict;
    logic                                                               resolve_taken;
    logic [GLOBAL_HISTORY_WIDTH-1:0]                                    ghr_out;
    logic [PATH_HISTORY_NUM_ENTRIES-1:0][PATH_HISTORY_HASH_WIDTH-1:0]   phr_out;
    logic                                                               recover_pulse;
    logic                                                               underflow_err;
    modport master (
        output pred_valid, pred_pc, pred_taken, resolve_valid, resolve_mispredict, resolve_taken,
        input  pred_ready, pred_tag, ghr_out, phr_out, recover_pulse, underflow_err
    );
    modport slave (
        input  pred_valid, pred_pc, pred_taken, resolve_valid, resolve_mispredict, resolve_taken,
        output pred_ready, pred_tag, ghr_out, phr_out, recover_pulse, underflow_err
    );
endinterface

// File: rtl/history_manager.sv
// history_manager: speculative global/path history with per-branch checkpoints for mispredict recovery
module history_manager #(
    parameter int GLOBAL_HISTORY_WIDTH     = 128,
    parameter int PATH_HISTORY_NUM_ENTRIES = 4,
    parameter int PATH_HISTORY_HASH_WIDTH  = 16,
    parameter int PC_WIDTH                 = 64,
    parameter int CKPT_DEPTH               = 8
) (
    input logic               clk,
    input logic               rst,
    history_manager_if.slave  bus
);
    localparam int W  = GLOBAL_HISTORY_WIDTH;
    localparam int N  = PATH_HISTORY_NUM_ENTRIES;
    localparam int H  = PATH_HISTORY_HASH_WIDTH;
    localparam int TW = $clog2(CKPT_DEPTH);
    typedef logic [N-1:0][H-1:0] phr_t;
    logic [W-1:0]  ghr;
    phr_t          phr;
    logic [W-1:0]  ckpt_ghr [CKPT_DEPTH];
    phr_t          ckpt_phr [CKPT_DEPTH];
    logic [H-1:0]  ckpt_hash [CKPT_DEPTH];
    logic [TW-1:0] wr_ptr, rd_ptr;
    logic [TW:0]   count;
    logic          recover_pulse, underflow_err;
    logic [H-1:0]  pc_hash;
    logic          push, pop, mis, empty;
    logic          unused_pc;
    function automatic phr_t shift_in(phr_t p, logic [H-1:0] h);
        phr_t r;
        r[0] = h;
        for (int k = 1; k < N; k++) r[k] = p[k-1];
        return r;
    endfunction
    assign unused_pc         = ^{bus.pred_pc[1:0], bus.pred_pc[PC_WIDTH-1:2+2*H]};
    assign pc_hash           = bus.pred_pc[2 +: H] ^ bus.pred_pc[2+H +: H];
    assign empty             = count == '0;
    assign bus.pred_ready    = count != (TW+1)'(CKPT_DEPTH) && !(bus.resolve_valid && bus.resolve_mispredict);
    assign push              = bus.pred_valid && bus.pred_ready;
    assign pop               = bus.resolve_valid && !bus.resolve_mispredict && !empty;
    assign mis               = bus.resolve_valid && bus.resolve_mispredict && !empty;
    assign bus.pred_tag      = wr_ptr;
    assign bus.ghr_out       = ghr;
    assign bus.phr_out       = phr;
    assign bus.recover_pulse = recover_pulse;
    assign bus.underflow_err = underflow_err;
    // Checkpoints hold the history seen before each branch; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ckpt_ghr[wr_ptr]  <= ghr;
            ckpt_phr[wr_ptr]  <= phr;
            ckpt_hash[wr_ptr] <= pc_hash;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr           <= '0;
            phr           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            recover_pulse <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            recover_pulse <= mis;
            if (bus.resolve_valid && empty) underflow_err <= 1'b1;
            if (mis) begin
                // Replay the oldest branch with its real outcome and drop everything younger.
                ghr    <= {ckpt_ghr[rd_ptr][W-2:0], bus.resolve_taken};
                phr    <= shift_in(ckpt_phr[rd_ptr], ckpt_hash[rd_ptr]);
                rd_ptr <= rd_ptr + 1'b1;
                wr_ptr <= rd_ptr + 1'b1;
                count  <= '0;
            end else begin
                if (push) begin
                    ghr    <= {ghr[W-2:0], bus.pred_taken};
                    phr    <= shift_in(phr, pc_hash);
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + push - pop;
            end
        end
    end
endmodule

// File: tb/tb_history_manager.sv
// tb_history_manager: randomized scoreboard bench against a queue-based model of the history manager
module tb_history_manager;
    localparam int W = 128, N = 4, H = 16, D = 8;
    typedef struct { logic [W-1:0] ghr; logic [N-1:0][H-1:0] phr; logic [H-1:0] hash; } ck_t;
    typedef struct { logic [W-1:0] ghr; logic [N-1:0][H-1:0] phr; logic rec; logic und; } exp_t;
    logic clk = 0, rst = 1;
    int   n_chk = 0, n_fail = 0;
    history_manager_if bus ();
    history_manager dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [W-1:0]        m_ghr;
    logic [N-1:0][H-1:0] m_phr;
    logic                m_und;
    int                  m_rd;
    ck_t                 q[$];
    exp_t                sb[$];
    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask
    function automatic logic [N-1:0][H-1:0] ins(logic [N-1:0][H-1:0] p, logic [H-1:0] h);
        logic [N-1:0][H-1:0] r;
        r[0] = h;
        for (int k = 1; k < N; k++) r[k] = p[k-1];
        return r;
    endfunction
    function automatic logic [H-1:0] hash_of(logic [63:0] pc);
        return H'((pc >> 2) ^ (pc >> (2 + H)));
    endfunction
    task automatic model_clear();
        m_ghr = '0; m_phr = '0; m_und = 0; m_rd = 0; q.delete(); sb.delete();
    endtask
    task automatic idle();
        bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_taken = 0;
        bus.resolve_valid = 0; bus.resolve_mispredict = 0; bus.resolve_taken = 0;
    endtask
    task automatic reset_dut();
        @(negedge clk);
        rst = 1;
        idle();
        #1;
        chk("rst_ghr", bus.ghr_out, '0);
        chk("rst_phr", W'(bus.phr_out), '0);
        chk("rst_ready", W'(bus.pred_ready), 1);
        chk("rst_recover", W'(bus.recover_pulse), 0);
        chk("rst_underflow", W'(bus.underflow_err), 0);
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask
    task automatic cycle(input logic pv, input logic [63:0] pc, input logic pt,
                         input logic rv, input logic rm, input logic rt);
        logic ready, acc;
        exp_t e;
        ck_t  c;
        @(negedge clk);
        bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_taken = pt;
        bus.resolve_valid = rv; bus.resolve_mispredict = rm; bus.resolve_taken = rt;
        #1;
        ready = q.size() != D && !(rv && rm);
        acc   = pv && ready;
        chk("pred_ready", W'(bus.pred_ready), W'(ready));
        if (pv) chk("pred_tag", W'(bus.pred_tag), W'((m_rd + q.size()) % D));
        e.rec = rv && rm && q.size() != 0;
        if (rv && q.size() == 0) m_und = 1;
        if (e.rec) begin
            c = q[0];
            m_ghr = {c.ghr[W-2:0], rt};
            m_phr = ins(c.phr, c.hash);
            m_rd = (m_rd + 1) % D;
            q.delete();
        end else begin
            if (rv && q.size() != 0) begin
                void'(q.pop_front());
                m_rd = (m_rd + 1) % D;
            end
            if (acc) begin
                c.ghr = m_ghr; c.phr = m_phr; c.hash = hash_of(pc);
                q.push_back(c);
                m_ghr = {m_ghr[W-2:0], pt};
                m_phr = ins(m_phr, c.hash);
            end
        end
        e.ghr = m_ghr; e.phr = m_phr; e.und = m_und;
        sb.push_back(e);
    endtask
    // Monitor: each scheduled edge yields one expected post-edge snapshot.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ghr_out", bus.ghr_out, e.ghr);
            chk("phr_out", W'(bus.phr_out), W'(e.phr));
            chk("recover_pulse", W'(bus.recover_pulse), W'(e.rec));
            chk("underflow_err", W'(bus.underflow_err), W'(e.und));
        end
    end
    initial begin
        idle();
        model_clear();
        reset_dut();
        cycle(1, 64'h1000, 1, 0, 0, 0);
        @(posedge clk); #2;
        chk("first_ghr", bus.ghr_out, 1);
        chk("first_phr0", W'(bus.phr_out[0]), 16'h0400);
        reset_dut();
        for (int i = 0; i < 9; i++) cycle(1, {$urandom, $urandom}, 1'($urandom), 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        reset_dut();
        cycle(1, 64'h2000, 1, 0, 0, 0);
        cycle(1, 64'h2004, 1, 0, 0, 0);
        cycle(1, 64'h2008, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        @(posedge clk); #2;
        chk("mis_ghr_zero", bus.ghr_out, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(1, {$urandom, $urandom}, 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, {$urandom, $urandom}, 1'($urandom), 1, 0, 0);
        cycle(1, {$urandom, $urandom}, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        reset_dut();
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 1);
        cycle(1, 64'h40, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, {$urandom, $urandom}, 1'($urandom), 0, 0, 0);
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) reset_dut();
            else cycle($urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom),
                       $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, 1'($urandom));
        end
        @(negedge clk);
        idle();
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/history_manager.md
HISTORY_MANAGER -- requirements
Module: history_manager

Interface
REQ-001 SHALL take parameter GLOBAL_HISTORY_WIDTH (default 128): GHR width in bits.
REQ-002 SHALL take parameter PATH_HISTORY_NUM_ENTRIES (default 4): number of PHR entries.
REQ-003 SHALL take parameter PATH_HISTORY_HASH_WIDTH (default 16): bits per PHR entry.
REQ-004 SHALL take parameter PC_WIDTH (default 64): branch PC width. Constraint: PC_WIDTH >= 2 + 2*PATH_HISTORY_HASH_WIDTH.
REQ-005 SHALL take parameter CKPT_DEPTH (default 8, power of 2): number of in-flight checkpoints. TW = log2(CKPT_DEPTH).
REQ-006 SHALL have one clock `clk` and one reset `rst`, which is asynchronous and active-high.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 pred_valid  in  1  a new predicted branch is presented.
REQ-010 pred_ready  out  1  the block can accept a prediction this cycle.
REQ-011 pred_pc  in  PC_WIDTH  PC of the predicted branch.
REQ-012 pred_taken  in  1  predicted direction.
REQ-013 pred_tag  out  TW  checkpoint slot assigned to the accepted prediction (equals wr_ptr).
REQ-014 resolve_valid  in  1  resolution of the oldest in-flight branch.
REQ-015 resolve_mispredict  in  1  the oldest branch was mispredicted.
REQ-016 resolve_taken  in  1  actual direction of the oldest branch.
REQ-017 ghr_out  out  GLOBAL_HISTORY_WIDTH  speculative GHR; bit 0 is newest. Feeds the index hash stage.
REQ-018 phr_out  out  PATH_HISTORY_NUM_ENTRIES x PATH_HISTORY_HASH_WIDTH  speculative PHR; entry 0 is newest.
REQ-019 recover_pulse  out  1  one-cycle pulse the cycle after a recovery.
REQ-020 underflow_err  out  1  sticky flag, set when a resolve arrives with no entry in flight.

Function
REQ-021 SHALL contain a circular checkpoint buffer of CKPT_DEPTH entries. Each entry holds {ghr, phr, pc_hash}, captured as the values before the update. Pointers are wr_ptr and rd_ptr (TW bits, wrap modulo CKPT_DEPTH); count is TW+1 bits.
REQ-022 pc_hash SHALL be pred_pc[2 +: PATH_HISTORY_HASH_WIDTH] XOR pred_pc[2+PATH_HISTORY_HASH_WIDTH +: PATH_HISTORY_HASH_WIDTH].
REQ-023 pred_ready SHALL be combinational: (count != CKPT_DEPTH) AND NOT (resolve_valid AND resolve_mispredict).
REQ-024 A push (pred_valid AND pred_ready) SHALL do all of the following:
  - write the checkpoint at wr_ptr;
  - ghr <= {ghr[W-2:0], pred_taken};
  - phr[0] <= pc_hash and phr[k] <= phr[k-1];
  - wr_ptr++ and count++.
REQ-025 ghr_out and phr_out SHALL be driven directly from registers. Latency from an accepted push to visible history is 1 cycle.
REQ-026 A correct resolve (resolve_valid, not mispredict, count>0) SHALL do rd_ptr++ and count-- only. History is unchanged.
REQ-027 A mispredict resolve (count>0) SHALL do all of the following:
  - ghr <= {ckpt[rd_ptr].ghr[W-2:0], resolve_taken};
  - phr <= ckpt[rd_ptr].phr shifted with ckpt[rd_ptr].pc_hash inserted at entry 0;
  - rd_ptr <= rd_ptr+1, wr_ptr <= rd_ptr+1, count <= 0, which flushes all younger entries;
  - recover_pulse <= 1 for the next cycle only.
REQ-028 When a correct resolve and a push occur in the same cycle, both SHALL take effect and count SHALL be unchanged.
REQ-029 A mispredict SHALL take priority over any push in the same cycle. pred_ready is low in that cycle, so no push occurs.
REQ-030 When full, pred_ready SHALL stay low even if a resolve pops in the same cycle. pred_ready is based on the registered count.
REQ-031 A resolve with count==0 SHALL:
  - leave the pointers, count and history unchanged;
  - set underflow_err, which stays set until rst.
REQ-032 resolve_taken and resolve_mispredict SHALL be ignored when resolve_valid is low.

Reset
REQ-033 Assertion of rst SHALL immediately (asynchronously) clear ghr, phr, wr_ptr, rd_ptr, count, recover_pulse and underflow_err to 0. pred_ready is then 1.
REQ-034 Checkpoint storage SHALL NOT require reset. Its contents are don't-care while count==0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight checkpoints. There are no partial updates on the release edge.

Verification
REQ-036 Reset, then push pc=0x1000 taken -> next cycle ghr_out=0x1, phr_out[0]=0x0400, pred_tag was 0.
REQ-037 Push 8 branches with no resolve -> pred_ready=0 after the 8th. A 9th pred_valid is not accepted and ghr_out is unchanged.
REQ-038 Push T,T,N (ghr=0b110), then resolve the oldest as mispredict with resolve_taken=0 -> ghr_out=0x0, count=0, recover_pulse high for exactly 1 cycle.
REQ-039 With 3 entries in flight, drive a correct resolve and a push in the same cycle -> count stays 3, rd_ptr and wr_ptr both advance; then push past index 7 -> pred_tag wraps to 0.
REQ-040 Drive a mispredict resolve and pred_valid in the same cycle -> pred_ready=0, the push is dropped, history equals the restored value.
REQ-041 Resolve with empty buffer -> underflow_err=1 and stays 1. Assert rst mid-stream with 5 entries in flight -> all outputs 0 and pred_ready=1 while rst is high.
